// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave  (input  in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
  modport master (output in_valid, in_data, input  in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program into instruction memory
// and holds the core off until a complete image has been written.
module imem_loader_lane #(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [VEC_W-1:0] d,
  output logic [VEC_W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)   q <= '0;
    else if (ld) q <= d;
endmodule

module imem_loader #(
  parameter int          MEM_BYTES = 100,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         core_hold
);
  localparam int          NUM_LANES = 4;
  localparam int          VEC_W     = 8;
  localparam int          IDX_W     = $clog2(NUM_LANES);
  localparam logic [15:0] MAX_W     = 16'(MEM_BYTES / 4);

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERROR} state_t;
  state_t state, state_nxt;

  logic [15:0]                       len, word_cnt, hdr;
  logic [IDX_W-1:0]                  byte_idx;
  logic                              acc, last_byte;
  logic [NUM_LANES-1:0]              lane_ld;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lane_q, wd_nxt;

  assign acc       = bus.in_valid && bus.in_ready;
  assign hdr       = {bus.in_data, len[7:0]};
  assign last_byte = (byte_idx == IDX_W'(NUM_LANES-1));

  // Lane wd_nxt folds in the byte arriving this cycle so the full word
  // can be registered on the same edge as the final byte.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_ld[g] = acc && (state == DATA) && (byte_idx == IDX_W'(g));
    assign wd_nxt[g]  = lane_ld[g] ? bus.in_data : lane_q[g];
    imem_loader_lane #(.VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .ld    (lane_ld[g]),
      .d     (bus.in_data),
      .q     (lane_q[g])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = HDR_LO;
      HDR_LO: if (acc) state_nxt = HDR_HI;
      HDR_HI: if (acc) begin
        if (hdr == 16'd0)     state_nxt = DONE;
        else if (hdr > MAX_W) state_nxt = ERROR;
        else                  state_nxt = DATA;
      end
      DATA:  if (acc && last_byte) state_nxt = WRITE;
      WRITE: state_nxt = (word_cnt + 16'd1 == len) ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
    bus.mem_we   = (state == WRITE);
    busy         = bus.in_ready || (state == WRITE);
    done         = (state == DONE);
    error        = (state == ERROR);
    core_hold    = (state != DONE);
  end

  // Address/data are latched with the final byte so they are stable
  // throughout the write cycle and hold afterwards.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      len           <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        HDR_LO: if (acc) len[7:0] <= bus.in_data;
        HDR_HI: if (acc) begin
          len[15:8] <= bus.in_data;
          word_cnt  <= '0;
          byte_idx  <= '0;
        end
        DATA: if (acc) begin
          if (last_byte) begin
            byte_idx      <= '0;
            bus.mem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
            bus.mem_wdata <= wd_nxt;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        WRITE: word_cnt <= word_cnt + 16'd1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a monitor checks every memory write
// against a queue of expected writes filled as stimulus is issued.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, error, core_hold;

  imem_loader_if bus();

  imem_loader #(.MEM_BYTES(100), .BASE_ADDR(32'd0)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .core_hold (core_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic [31:0] prog [7] = '{32'h00002083, 32'h00402103, 32'h00802183, 32'h022080b3,
                            32'h00308463, 32'h00002103, 32'h00202623};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      wr_t e;
      chk("wr_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("wr_busy", {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, required no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  // All tasks start and end just after a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: in_ready %b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gapped, input int nbytes);
    if (nbytes == 4) exp_q.push_back('{addr: addr, data: w});
    for (int k = 0; k < nbytes; k++)
      send_byte(w[8*k +: 8], (gapped && ((addr[7:0] + k) % 3 == 1)) ? 3 : 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd0);
  endtask

  task automatic load_prog(input string tag, input bit gapped, input bit mid_start);
    pulse_start();
    send_hdr(16'd7);
    for (int i = 0; i < 7; i++) begin
      send_word(prog[i], 32'(4*i), gapped, 4);
      if (mid_start && i == 2) begin
        pulse_start();
        chk("mid_start_busy", {31'd0, busy}, 32'd1);
      end
    end
    wait_done(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_flags"}, {28'd0, busy, done, error, core_hold}, 32'h1);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_flags", {28'd0, busy, done, error, core_hold}, 32'h1);

    load_prog("basic", 1'b0, 1'b0);
    load_prog("gapped", 1'b1, 1'b0);

    pulse_start();
    send_hdr(16'd0);
    wait_done("zero");

    pulse_start();
    send_hdr(16'd26);
    chk("ovf_flags", {28'd0, busy, done, error, core_hold}, 32'h3);
    repeat (3) @(negedge clk);
    chk("ovf_hold", {28'd0, busy, done, error, core_hold}, 32'h3);
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h00000013, 32'd0, 1'b0, 4);
    wait_done("recover");

    load_prog("midstart", 1'b0, 1'b1);

    pulse_start();
    chk("reload_flags", {28'd0, busy, done, error, core_hold}, 32'h9);
    chk("reload_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Restart from HDR_LO and abandon the load partway through word 3.
    send_hdr(16'd7);
    for (int i = 0; i < 3; i++) send_word(prog[i], 32'(4*i), 1'b0, 4);
    send_word(prog[3], 32'd12, 1'b0, 2);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {27'd0, bus.in_ready, busy, done, error, core_hold}, 32'h1);

    load_prog("fresh", 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the byte-addressable, little-endian instruction memory.
- Accepts a program as a byte stream over a valid/ready interface: a 16-bit word-count header followed by instruction bytes, LSB first.
- Assembles each group of four bytes into a 32-bit word and writes it into instruction memory.
- Holds the core off (core_hold) until a complete program has been loaded.

Parameters:
- MEM_BYTES, 100, instruction memory size in bytes; maximum loadable words = MEM_BYTES/4 (25 at default).
- BASE_ADDR, 0, byte address of the first word written; word i goes to BASE_ADDR + 4*i.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all loader state.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored in all other states.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a byte transfers on an edge where in_valid && in_ready.
- mem_we  output  1  instruction memory write enable; high for exactly one cycle per word.
- mem_addr  output  32  byte address of the word being written; always 4-aligned.
- mem_wdata  output  32  word data {b3,b2,b1,b0}; the first-received byte goes to bits [7:0].
- busy  output  1  high in HDR_LO, HDR_HI, DATA and WRITE.
- done  output  1  high in DONE.
- error  output  1  high in ERROR.
- core_hold  output  1  high in every state except DONE; drives the core's reset/stall.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; byte_idx, word_cnt and len clear to 0.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, error=0, core_hold=1.
  - Memory contents are not touched.
  - Reset asserted mid-load abandons the load immediately; words already written stay in memory.
- IDLE: in_ready=0. start moves to HDR_LO.
- HDR_LO: in_ready=1. An accepted byte is stored in len[7:0]; move to HDR_HI.
- HDR_HI: in_ready=1. On an accepted byte, len = {byte, len[7:0]}, then:
  - len == 0: go to DONE; no writes occur.
  - len > MEM_BYTES/4: go to ERROR.
  - otherwise: go to DATA with word_cnt=0 and byte_idx=0.
- DATA: in_ready=1.
  - Each accepted byte is placed in lane byte_idx of the assembly register, then byte_idx increments.
  - On the byte that makes byte_idx reach 4, move to WRITE and reset byte_idx to 0.
  - Idle cycles with in_valid=0 are allowed anywhere in the stream; state and counters hold.
- WRITE: lasts exactly one cycle.
  - Outputs: in_ready=0, mem_we=1, mem_addr=BASE_ADDR+4*word_cnt, mem_wdata=assembled word.
  - word_cnt increments. If the new word_cnt == len, go to DONE; else return to DATA.
- Write latency: the 4th byte is accepted at edge k; mem_we is high during cycle k..k+1; memory captures the word at edge k+1.
- mem_addr and mem_wdata are registered and stable for the whole cycle in which mem_we=1. Outside WRITE they hold their last value.
- DONE: done=1, core_hold=0, in_ready=0. start returns to HDR_LO for a reload, and core_hold rises in the same edge.
- ERROR: error=1, core_hold=1, in_ready=0. Only start (goes to HDR_LO) or reset leaves ERROR.
- start is ignored in HDR_LO, HDR_HI, DATA and WRITE.
- Bytes presented while in_ready=0 are not consumed. The source must hold them until they are accepted.
- Widths:
  - len and word_cnt are 16 bits.
  - mem_addr = BASE_ADDR + {word_cnt,2'b00}, computed in 32 bits with no wrap check beyond the len bound.

Test Plan:
- Basic load: reset, start, stream 07 00, then the 7-word program bytes 83 20 00 00 | 03 21 40 00 | 83 21 80 00 | b3 80 20 02 | 63 84 30 00 | 03 21 00 00 | 23 26 20 00.
  - Required: 7 mem_we pulses at addresses 0,4,...,24.
  - Data 0x00002083, 0x00402103, 0x00802183, 0x022080b3, 0x00308463, 0x00002103, 0x00202623.
  - Then done=1 and core_hold=0.
- Gapped stream: same program with in_valid deasserted 3 cycles between random bytes.
  - Required: identical writes; in_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Zero length: start, header 00 00 -> DONE with no mem_we pulse.
- Overflow: header 1A 00 (26 words) -> error=1, core_hold=1, no writes.
  - Then start plus header 01 00 and bytes 13 00 00 00 -> one write of 0x00000013 at address 0, then done=1.
- Reset mid-load: assert reset after word 3's second byte.
  - Required: outputs go to reset values immediately and the state is IDLE.
  - A fresh start plus a full load then completes normally.
- Start while busy: pulse start during DATA -> ignored, and the load completes unchanged. Start in DONE -> core_hold=1 and busy=1 on the next cycle.
